// File: rtl/fifo_rd_burst_ctrl.sv
// Read-domain burst drain engine: pops a programmed word count from the FIFO into a 2-entry valid/ready buffer.
// Optional macro RD_TIMEOUT_EN aborts a burst after TIMEOUT_CYCLES consecutive empty-stall cycles.
module fifo_rd_burst_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_left,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  timeout
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_words_left;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_buf_cnt;
  logic                  w_out_fire;
  logic                  w_push;
  logic                  w_to_hit;

  assign w_out_fire = (r_buf_cnt != 2'd0) && out_ready;
  // A full buffer may still accept a word when the head leaves on the same edge.
  assign w_push     = (r_state == S_READ) && !rempty && (r_words_left != '0) &&
                      ((r_buf_cnt < 2'd2) || w_out_fire);

  assign rinc       = w_push;
  assign busy       = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign words_left = r_words_left;
  assign out_valid  = (r_buf_cnt != 2'd0);
  assign out_data   = r_buf0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (burst_len == '0) ? S_DONE : S_READ;
      S_READ: begin
        if ((w_push && (r_words_left == ONE)) || (r_words_left == '0) || w_to_hit)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_out_fire))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_DONE)
        r_words_left <= '0;
      else if ((r_state == S_IDLE) && start)
        r_words_left <= (burst_len > DEPTH) ? DEPTH : burst_len;
      else if (w_push)
        r_words_left <= r_words_left - ONE;
    end
  end

  // Two-entry output buffer; r_buf0 is always the head.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_buf_cnt <= 2'd0;
    end else begin
      case ({w_push, w_out_fire})
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= rdata;
          else                   r_buf1 <= rdata;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_stall;

  assign w_stall  = (r_state == S_READ) && rempty && (r_words_left != '0);
  assign w_to_hit = w_stall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout  = r_timeout;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (!w_stall || w_to_hit) r_to_cnt <= '0;
      else                      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_to_hit             = 1'b0;
  assign timeout              = 1'b0;
`endif

endmodule
